// File: rtl/dfdd_pkg.sv
// Shared constants and types for the vertical 2x upsample sequencer:
// fp16 tap values, default phase kernels, sequencer states, width helpers.
package dfdd_pkg;

  localparam logic [15:0] FP16_ZERO    = 16'h0000;
  localparam logic [15:0] FP16_QUARTER = 16'h3400;
  localparam logic [15:0] FP16_THREE_Q = 16'h3A00;

  // Tap 0 sits in the least-significant slot of the flattened window.
  localparam logic [63:0] KERNEL_P0_DEFAULT = {FP16_ZERO, FP16_ZERO, FP16_THREE_Q, FP16_QUARTER};
  localparam logic [63:0] KERNEL_P1_DEFAULT = {FP16_QUARTER, FP16_THREE_Q, FP16_ZERO, FP16_ZERO};

  typedef enum logic {
    ST_PASS   = 1'b0,
    ST_REPLAY = 1'b1
  } seq_state_t;

  function automatic logic width_ok(input logic [15:0] w, input int unsigned max_cols);
    return (w != 16'd0) && ({16'd0, w} <= max_cols);
  endfunction

  function automatic logic [15:0] clamp_width(input logic [15:0] w, input int unsigned max_cols);
    return width_ok(w, max_cols) ? w : max_cols[15:0];
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One-row store of vertical windows: single write port, single registered read port.
module window_line_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/upsample_v_sequencer.sv
// Vertical 2x upsample sequencer: passes each input row through with the phase-0
// kernel, then replays the buffered row with the phase-1 kernel on odd output rows.
module upsample_v_sequencer
  import dfdd_pkg::*;
#(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_HEIGHT = 4,
  parameter int MAX_COLS      = 1024,
  parameter logic [WINDOW_HEIGHT*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] KERNEL_P0 = KERNEL_P0_DEFAULT,
  parameter logic [WINDOW_HEIGHT*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] KERNEL_P1 = KERNEL_P1_DEFAULT
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [15:0]                                       width_i,
  input  logic [WINDOW_HEIGHT*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] window_i,
  input  logic [15:0]                                       col_i,
  input  logic [15:0]                                       row_i,
  input  logic                                              valid_i,
  output logic                                              ready_o,
  output logic [WINDOW_HEIGHT*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] window_o,
  output logic [WINDOW_HEIGHT*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] kernel_o,
  output logic [15:0]                                       col_o,
  output logic [15:0]                                       row_o,
  output logic                                              valid_o,
  output logic                                              busy_o,
  output logic                                              err_o
);

  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int WIN_W        = WINDOW_HEIGHT * FP_WIDTH_REG;
  localparam int ADDR_W       = $clog2(MAX_COLS);

  seq_state_t        state;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;
  logic [15:0]       exp_col;
  logic [15:0]       w_q;
  logic [15:0]       row_q;
  logic [15:0]       rd_cnt;
  logic              sel_buf_p1;
  logic              vld_p1;
  logic [WIN_W-1:0]  win_p1;
  logic [WIN_W-1:0]  kernel_p1;
  logic [WIN_W-1:0]  rd_data;
  logic [15:0]       col_p1;
  logic [15:0]       row_p1;

  logic              xfer;
  logic              col0;
  logic              width_bad;
  logic [15:0]       w_eff;
  logic              last_col;
  logic              rd_en;
  logic              rd_last;

  assign xfer      = valid_i & ready_q;
  assign col0      = (col_i == 16'd0);
  assign width_bad = !width_ok(width_i, MAX_COLS);
  // A col-0 window defines the row width for its own last-column test.
  assign w_eff     = col0 ? clamp_width(width_i, MAX_COLS) : w_q;
  assign last_col  = (col_i == (w_eff - 16'd1));
  assign rd_en     = (state == ST_REPLAY);
  assign rd_last   = (rd_cnt == (w_q - 16'd1));

  window_line_buffer #(
    .DATA_W (WIN_W),
    .DEPTH  (MAX_COLS)
  ) u_line_buffer (
    .clk     (clk_i),
    .wr_en   (xfer),
    .wr_addr (col_i[ADDR_W-1:0]),
    .wr_data (window_i),
    .rd_en   (rd_en),
    .rd_addr (rd_cnt[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // Output stage p1: phase-0 beats come from win_p1, phase-1 beats from the buffer read register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_PASS;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      exp_col    <= 16'd0;
      w_q        <= clamp_width(16'd0, MAX_COLS);
      row_q      <= 16'd0;
      rd_cnt     <= 16'd0;
      sel_buf_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      win_p1     <= '0;
      kernel_p1  <= '0;
      col_p1     <= 16'd0;
      row_p1     <= 16'd0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        ST_PASS: begin
          if (xfer) begin
            win_p1     <= window_i;
            kernel_p1  <= KERNEL_P0;
            col_p1     <= col_i;
            row_p1     <= {row_i[14:0], 1'b0};
            vld_p1     <= 1'b1;
            sel_buf_p1 <= 1'b0;
            if (col0) begin
              w_q   <= w_eff;
              row_q <= row_i;
              if (width_bad) err_q <= 1'b1;
            end
            if (col_i != exp_col) err_q <= 1'b1;
            if (last_col) begin
              state   <= ST_REPLAY;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              rd_cnt  <= 16'd0;
              exp_col <= 16'd0;
            end else begin
              exp_col <= col_i + 16'd1;
            end
          end
        end
        ST_REPLAY: begin
          kernel_p1  <= KERNEL_P1;
          col_p1     <= rd_cnt;
          row_p1     <= {row_q[14:0], 1'b1};
          vld_p1     <= 1'b1;
          sel_buf_p1 <= 1'b1;
          if (rd_last) begin
            state   <= ST_PASS;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            rd_cnt <= rd_cnt + 16'd1;
          end
        end
        default: begin
          state   <= ST_PASS;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;
  assign valid_o  = vld_p1;
  assign window_o = sel_buf_p1 ? rd_data : win_p1;
  assign kernel_o = kernel_p1;
  assign col_o    = col_p1;
  assign row_o    = row_p1;

endmodule

// File: doc/upsample_v_sequencer.md
UPSAMPLE_V_SEQUENCER -- requirements
Module: upsample_v_sequencer

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5, fp exponent width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10, fp fraction width; FP_WIDTH_REG = 1+EXP_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have parameter WINDOW_HEIGHT, default 4, vertical taps per window (WINDOW_WIDTH fixed at 1).
REQ-004 SHALL have parameter MAX_COLS, default 1024, line buffer depth in windows.
REQ-005 SHALL have parameter KERNEL_P0, default taps {0x3400,0x3A00,0x0000,0x0000}, phase-0 kernel (tap 0 first).
REQ-006 SHALL have parameter KERNEL_P1, default taps {0x0000,0x0000,0x3A00,0x3400}, phase-1 kernel.
REQ-007 clk_i  in  1  sole clock; all state on rising edge.
REQ-008 rst_i  in  1  reset, asynchronous, active-high.
REQ-009 width_i  in  16  active columns per input row; sampled when the col-0 window is accepted.
REQ-010 window_i  in  FP_WIDTH_REG x [WINDOW_HEIGHT][1]  input vertical window.
REQ-011 col_i, row_i  in  16 each  input window coordinates.
REQ-012 valid_i  in  1  input window present.
REQ-013 ready_o  out  1  sequencer accepts window this cycle; transfer = valid_i & ready_o.
REQ-014 window_o, kernel_o  out  FP_WIDTH_REG x [WINDOW_HEIGHT][1]  to convolution_floating_point.
REQ-015 col_o, row_o  out  16 each  output coordinates.
REQ-016 valid_o  out  1  output beat valid; no downstream backpressure.
REQ-017 busy_o  out  1  high in REPLAY state.
REQ-018 err_o  out  1  sticky protocol error flag.

Function
REQ-019 SHALL implement states PASS and REPLAY; ready_o = (state==PASS), registered.
REQ-020 In PASS, each transfer SHALL write window_i to buffer address col_i and drive, one cycle later, window_o=window_i, kernel_o=KERNEL_P0, col_o=col_i, row_o=2*row_i, valid_o=1.
REQ-021 A PASS transfer with col_i == W-1 (W = latched width) SHALL move the state to REPLAY on the next edge.
REQ-022 In REPLAY, the block SHALL read buffer addresses 0..W-1, one per cycle, and emit each one cycle after its read with kernel_o=KERNEL_P1, col_o=address, row_o=2*row+1 (row latched at col 0), valid_o=1.
REQ-023 Phase-1 col 0 SHALL appear exactly two cycles after the last phase-0 transfer; phase-0 and phase-1 beats of a row SHALL be gapless.
REQ-024 State SHALL return to PASS on the edge after the address W-1 read, so ready_o is high in the cycle phase-1 col W-1 is on valid_o.
REQ-025 valid_o SHALL be 0 in any cycle without a beat; window_o/kernel_o/col_o/row_o hold their last values.
REQ-026 width_i == 0 or > MAX_COLS SHALL set err_o and clamp W to MAX_COLS.
REQ-027 A transfer whose col_i differs from the expected column counter (0 after reset/REPLAY, else previous+1) SHALL set err_o; the window is still processed at address col_i.
REQ-028 row_o SHALL be computed modulo 2^16 (2*row_i wraps).
REQ-029 valid_i while ready_o=0 SHALL be ignored without error.

Reset
REQ-030 rst_i SHALL force state PASS, ready_o=1, valid_o=0, busy_o=0, err_o=0, column counter 0, window_o/kernel_o/col_o/row_o=0.
REQ-031 rst_i mid-REPLAY SHALL abandon the row; buffer contents need not be cleared.

Structure
REQ-032 Default kernels, fp16 constants (0.25=0x3400, 0.75=0x3A00) and the state enum SHALL live in shared package dfdd_pkg.
REQ-033 The line buffer SHALL be one sub-module, window_line_buffer (1 write, 1 synchronous read port, MAX_COLS x WINDOW_HEIGHT*FP_WIDTH_REG).

Verification
REQ-034 W=4, row 3, cols 0..3 back-to-back -> phase-0 beats row_o=6, cols 0..3; then cols 0..3 with row_o=7 and KERNEL_P1; 8 contiguous valid_o cycles.
REQ-035 valid_i held during REPLAY -> ready_o=0 for 4 cycles, no extra beats, err_o=0; next row accepted the cycle phase-1 col 3 is output.
REQ-036 col sequence 0,1,3 with W=4 -> err_o=1 sticky after col 3 accepted; beat still emitted with col_o=3.
REQ-037 width_i=0 at col 0 -> err_o=1, W=MAX_COLS.
REQ-038 rst_i asserted at second REPLAY beat -> valid_o=0 and ready_o=1 immediately, next row starts clean.
REQ-039 row_i=0x8001 -> row_o=0x0002 then 0x0003.
